// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic sensor front end: light feedback
// encodings and the emergency preemption state type.
package traffic_pkg;

  // Controller feedback patterns, {Red,Yellow,Green}
  localparam logic [2:0] LIGHT_RED        = 3'b100;
  localparam logic [2:0] LIGHT_RED_YELLOW = 3'b110;
  localparam logic [2:0] LIGHT_GREEN      = 3'b001;
  localparam logic [2:0] LIGHT_YELLOW     = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    HOLD,
    LOCKOUT
  } emerg_state_t;

  // True when the feedback is one of the four aspects the controller may show
  function automatic logic light_legal(input logic [2:0] lights);
    return (lights == LIGHT_RED) || (lights == LIGHT_RED_YELLOW) ||
           (lights == LIGHT_GREEN) || (lights == LIGHT_YELLOW);
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer followed by a stability filter: the output level
// follows the synchronized input only after DEBOUNCE_CYCLES consecutive
// samples disagree with the current output.
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync_a;
  logic          sync_b;
  logic [CW-1:0] cnt;

  // Bring the asynchronous level into the clock domain
  // NOTE: non-blocking assignments make sync_b take the old sync_a, giving two real flop stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // Count consecutive disagreeing samples; any agreeing sample restarts the run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync_b == level) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      level <= sync_b;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_sensor_frontend.sv
// Front end between raw roadside sensors and the signal controller:
// debounces loop, pedestrian and emergency inputs, turns rising edges into
// queued one-cycle car_detected pulses, runs the emergency preemption FSM
// with hold and timeout lockout, and monitors the lights feedback.
module traffic_sensor_frontend
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8,
  parameter int EMERG_MAX       = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       loop_raw,
  input  logic       ped_raw,
  input  logic       emerg_raw,
  input  logic [2:0] lights,
  output logic       car_detected,
  output logic       emergency,
  output logic       emerg_fault,
  output logic       light_fault
);

  localparam int EW = $clog2(EMERG_MAX + 1);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic          loop_lvl;
  logic          ped_lvl;
  logic          emerg_lvl;
  logic          loop_q;
  logic          ped_q;
  logic          emerg_req;
  logic          loop_evt;
  logic          ped_evt;
  logic [1:0]    pending;
  logic [2:0]    pend_sum;
  emerg_state_t  state;
  logic [HW-1:0] hold_cnt;
  logic [EW-1:0] emerg_cnt;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_loop (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (loop_raw),
    .level (loop_lvl)
  );

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ped (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (ped_raw),
    .level (ped_lvl)
  );

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_emerg (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (emerg_raw),
    .level (emerg_lvl)
  );

  // Previous filtered levels for edge detection; the emergency request is
  // taken from the same stage so both paths see equal latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loop_q    <= 1'b0;
      ped_q     <= 1'b0;
      emerg_req <= 1'b0;
    end else begin
      loop_q    <= loop_lvl;
      ped_q     <= ped_lvl;
      emerg_req <= emerg_lvl;
    end
  end

  // Rising edges only, and the next pending count (add events, retire one pulse)
  // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
  always_comb begin
    loop_evt = loop_lvl & ~loop_q;
    ped_evt  = ped_lvl & ~ped_q;
    pend_sum = 3'(pending) + 3'(loop_evt) + 3'(ped_evt) - 3'(pending != 2'd0);
  end

  // Pending queue saturates at three; one pulse issued per cycle while non-empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending      <= 2'd0;
      car_detected <= 1'b0;
    end else begin
      pending      <= (pend_sum > 3'd3) ? 2'd3 : pend_sum[1:0];
      car_detected <= (pending != 2'd0);
    end
  end

  // Emergency preemption FSM with hold extension and continuous-assertion timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      emerg_cnt   <= '0;
      emergency   <= 1'b0;
      emerg_fault <= 1'b0;
    end else begin
      emergency <= (state == ACTIVE) || (state == HOLD);
      emerg_cnt <= emergency ? emerg_cnt + 1'b1 : '0;
      if (emergency && (emerg_cnt == EW'(EMERG_MAX - 1))) begin
        // Override asserted too long: drop it now and latch the fault
        state       <= LOCKOUT;
        hold_cnt    <= '0;
        emerg_cnt   <= '0;
        emergency   <= 1'b0;
        emerg_fault <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (emerg_req) state <= ACTIVE;
          end
          ACTIVE: begin
            if (!emerg_req) begin
              state    <= HOLD;
              hold_cnt <= '0;
            end
          end
          HOLD: begin
            if (emerg_req) begin
              state    <= ACTIVE;
              hold_cnt <= '0;
            end else if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
              state <= IDLE;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          LOCKOUT: begin
            if (!emerg_req) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Sticky lights monitor: illegal aspect, or not all-red once the override
  // has been in force for three consecutive cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      light_fault <= 1'b0;
    end else if (!light_legal(lights) ||
                 (emergency && (emerg_cnt >= EW'(2)) && (lights != LIGHT_RED))) begin
      light_fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_traffic_sensor_frontend.sv
// Self-checking bench for traffic_sensor_frontend. A reference model fed from
// the per-edge input history predicts car_detected pulse edges and the
// emergency/fault levels; a monitor on the falling edge compares the DUT.
module tb_traffic_sensor_frontend;

  localparam int D    = 4;
  localparam int H    = 8;
  localparam int EMAX = 255;
  localparam int NMAX = 4096;

  // History rows
  localparam int S_LR = 0;
  localparam int S_PR = 1;
  localparam int S_ER = 2;
  localparam int S_FL = 3;
  localparam int S_FP = 4;
  localparam int S_FE = 5;
  localparam int S_EM = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       loop_raw = 1'b0;
  logic       ped_raw = 1'b0;
  logic       emerg_raw = 1'b0;
  logic [2:0] lights = 3'b100;
  logic       car_detected;
  logic       emergency;
  logic       emerg_fault;
  logic       light_fault;

  traffic_sensor_frontend #(
    .DEBOUNCE_CYCLES (D),
    .HOLD_CYCLES     (H),
    .EMERG_MAX       (EMAX)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .loop_raw     (loop_raw),
    .ped_raw      (ped_raw),
    .emerg_raw    (emerg_raw),
    .lights       (lights),
    .car_detected (car_detected),
    .emergency    (emergency),
    .emerg_fault  (emerg_fault),
    .light_fault  (light_fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit em;
    bit ef;
    bit lf;
    int edge_no;
  } lvl_t;

  bit   hist [7][NMAX];
  lvl_t exp_lvl [$];
  int   exp_car [$];
  int   sched [$];
  int   cur;
  int   last_pulse;
  int   lock_edge;
  int   unlock_base;
  int   run;
  bit   locked;
  bit   m_em;
  bit   m_efault;
  bit   m_lf;
  bit   win;
  int   t;
  int   nrise;
  int   outstanding;
  int   slot;

  function automatic bit h(input int s, input int i);
    return (i < 0) ? 1'b0 : hist[s][i];
  endfunction

  // Filtered level after edge ti: takes the synchronized value once the last
  // D synchronized samples (raw seen two edges earlier) all agree
  function automatic bit filt_at(input int sr, input int sf, input int ti);
    bit v;
    v = h(sr, ti - 2);
    for (int k = 3; k <= D + 1; k++)
      if (h(sr, ti - k) != v) return h(sf, ti - 1);
    return v;
  endfunction

  function automatic bit lights_ok(input logic [2:0] l);
    return (l == 3'b100) || (l == 3'b110) || (l == 3'b001) || (l == 3'b010);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      cur         = 0;
      last_pulse  = -1;
      lock_edge   = 0;
      unlock_base = 0;
      run         = 0;
      locked      = 1'b0;
      m_efault    = 1'b0;
      m_lf        = 1'b0;
      sched.delete();
      exp_car.delete();
      exp_lvl.delete();
    end else begin
      t = cur;
      if (t >= NMAX) begin
        $display("FAIL model history overflow at edge %0d", t);
        $fatal(1, "model history overflow");
      end
      hist[S_LR][t] = loop_raw;
      hist[S_PR][t] = ped_raw;
      hist[S_ER][t] = emerg_raw;
      hist[S_FL][t] = filt_at(S_LR, S_FL, t);
      hist[S_FP][t] = filt_at(S_PR, S_FP, t);
      hist[S_FE][t] = filt_at(S_ER, S_FE, t);

      // Each filtered rising edge becomes a pulse, earliest two edges later,
      // queued behind earlier pulses; no more than three may be waiting
      while (sched.size() > 0 && sched[0] <= t) void'(sched.pop_front());
      nrise = 0;
      if (h(S_FL, t) && !h(S_FL, t - 1)) nrise++;
      if (h(S_FP, t) && !h(S_FP, t - 1)) nrise++;
      for (int n = 0; n < nrise; n++) begin
        outstanding = 0;
        foreach (sched[i]) if (sched[i] > t + 1) outstanding++;
        if (outstanding < 3) begin
          slot = (last_pulse + 1 > t + 2) ? last_pulse + 1 : t + 2;
          sched.push_back(slot);
          exp_car.push_back(slot);
          last_pulse = slot;
        end
      end

      // Override is on while the filtered request was high within the last
      // hold window (three edges of pipeline), unless locked out by timeout
      win = 1'b0;
      for (int k = 0; k <= H; k++)
        if ((t - 3 - k) >= unlock_base && h(S_FE, t - 3 - k)) win = 1'b1;
      if (locked) begin
        m_em = 1'b0;
        if (t > lock_edge && !h(S_FE, t - 2)) begin
          locked      = 1'b0;
          unlock_base = t - 1;
        end
      end else if (run == EMAX) begin
        m_em      = 1'b0;
        locked    = 1'b1;
        lock_edge = t;
        m_efault  = 1'b1;
      end else begin
        m_em = win;
      end
      run = m_em ? run + 1 : 0;
      hist[S_EM][t] = m_em;

      if (!lights_ok(lights) ||
          (h(S_EM, t - 1) && h(S_EM, t - 2) && h(S_EM, t - 3) && lights != 3'b100))
        m_lf = 1'b1;

      exp_lvl.push_back('{m_em, m_efault, m_lf, t});
      cur++;
    end
  end

  // ---------------- monitor ----------------
  lvl_t exp_now;
  bit   exp_pulse;
  int   car_count;
  int   car_first;
  int   car_last;
  int   em_first;
  int   em_last;

  always @(negedge clk) begin
    if (rst_n && exp_lvl.size() > 0) begin
      exp_now = exp_lvl.pop_front();
      check("levels{emergency,emerg_fault,light_fault}",
            {29'd0, emergency, emerg_fault, light_fault},
            {29'd0, exp_now.em, exp_now.ef, exp_now.lf});
      exp_pulse = (exp_car.size() > 0) && (exp_car[0] == exp_now.edge_no);
      if (exp_pulse) void'(exp_car.pop_front());
      check("car_detected", {31'd0, car_detected}, {31'd0, exp_pulse});
      if (car_detected) begin
        car_count++;
        if (car_first < 0) car_first = exp_now.edge_no;
        car_last = exp_now.edge_no;
      end
      if (emergency) begin
        if (em_first < 0) em_first = exp_now.edge_no;
        em_last = exp_now.edge_no;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset for two edges with quiet inputs; the caller then sets edge-0
  // inputs and releases rst_n
  task automatic apply_reset();
    rst_n     = 1'b0;
    loop_raw  = 1'b0;
    ped_raw   = 1'b0;
    emerg_raw = 1'b0;
    lights    = 3'b100;
    tick(2);
    car_count = 0;
    car_first = -1;
    car_last  = -1;
    em_first  = -1;
    em_last   = -1;
  endtask

  task automatic random_phase(input int ncyc, input bit allow_illegal);
    int lr_left;
    int pr_left;
    int er_left;
    int r;
    lr_left = 0;
    pr_left = 0;
    er_left = 0;
    apply_reset();
    rst_n = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      if (lr_left == 0) begin loop_raw = ~loop_raw; lr_left = $urandom_range(1, 12); end
      if (pr_left == 0) begin ped_raw = ~ped_raw; pr_left = $urandom_range(1, 12); end
      if (er_left == 0) begin emerg_raw = ~emerg_raw; er_left = $urandom_range(1, 40); end
      lr_left--;
      pr_left--;
      er_left--;
      r = $urandom_range(0, 99);
      if (allow_illegal && r == 0) lights = 3'($urandom_range(0, 7));
      else if (r < 85) lights = 3'b100;
      else begin
        case ($urandom_range(0, 3))
          0: lights = 3'b100;
          1: lights = 3'b110;
          2: lights = 3'b001;
          default: lights = 3'b010;
        endcase
      end
      tick(1);
    end
  endtask

  initial begin
    // Reset state
    apply_reset();
    check("reset car_detected", {31'd0, car_detected}, 32'd0);
    check("reset emergency", {31'd0, emergency}, 32'd0);
    check("reset emerg_fault", {31'd0, emerg_fault}, 32'd0);
    check("reset light_fault", {31'd0, light_fault}, 32'd0);

    // Loop held high from edge 0: one pulse at edge 7
    loop_raw = 1'b1;
    lights   = 3'b001;
    rst_n    = 1'b1;
    tick(40);
    check("held loop pulse count", car_count, 1);
    check("held loop pulse edge", car_first, 7);

    // Three-cycle glitch is filtered out
    apply_reset();
    loop_raw = 1'b1;
    rst_n    = 1'b1;
    tick(3);
    loop_raw = 1'b0;
    tick(30);
    check("glitch pulse count", car_count, 0);

    // Loop and pedestrian together: pulses at 7 and 8
    apply_reset();
    loop_raw = 1'b1;
    ped_raw  = 1'b1;
    rst_n    = 1'b1;
    tick(30);
    check("dual pulse count", car_count, 2);
    check("dual first pulse edge", car_first, 7);
    check("dual last pulse edge", car_last, 8);

    // Emergency for 20 cycles: on from edge 8, last high edge 20+16-1
    apply_reset();
    emerg_raw = 1'b1;
    rst_n     = 1'b1;
    tick(20);
    emerg_raw = 1'b0;
    tick(40);
    check("emergency first edge", em_first, 8);
    check("emergency last edge", em_last, 35);
    check("hold emerg_fault", {31'd0, emerg_fault}, 32'd0);

    // Stuck request: 255 cycles of override then lockout, re-arm after release
    apply_reset();
    emerg_raw = 1'b1;
    rst_n     = 1'b1;
    tick(300);
    check("stuck emergency first edge", em_first, 8);
    check("stuck emergency last edge", em_last, 8 + EMAX - 1);
    check("stuck emerg_fault", {31'd0, emerg_fault}, 32'd1);
    check("lockout emergency", {31'd0, emergency}, 32'd0);
    emerg_raw = 1'b0;
    tick(20);
    emerg_raw = 1'b1;
    tick(30);
    check("rearmed after release", {31'd0, (em_last > 300)}, 32'd1);
    check("emerg_fault sticky", {31'd0, emerg_fault}, 32'd1);

    // Illegal lights for one cycle
    apply_reset();
    rst_n = 1'b1;
    tick(5);
    lights = 3'b111;
    tick(1);
    lights = 3'b100;
    #4;
    check("light_fault after 111", {31'd0, light_fault}, 32'd1);
    tick(20);
    check("light_fault sticky", {31'd0, light_fault}, 32'd1);
    apply_reset();
    check("light_fault cleared by reset", {31'd0, light_fault}, 32'd0);

    // Reset mid-hold drops emergency without waiting for a clock
    emerg_raw = 1'b1;
    rst_n     = 1'b1;
    tick(20);
    emerg_raw = 1'b0;
    tick(10);
    check("emergency in hold", {31'd0, emergency}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset emergency", {31'd0, emergency}, 32'd0);

    // Reset with two pulses pending discards them
    apply_reset();
    loop_raw = 1'b1;
    ped_raw  = 1'b1;
    rst_n    = 1'b1;
    tick(7);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset car_detected", {31'd0, car_detected}, 32'd0);
    apply_reset();
    rst_n = 1'b1;
    tick(20);
    check("pending discarded by reset", car_count, 0);

    // Randomized traffic against the model
    random_phase(600, 1'b0);
    random_phase(600, 1'b0);
    random_phase(600, 1'b1);
    random_phase(600, 1'b0);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
